// File: rtl/mem_arb_pkg.sv
// Shared constants and state encoding for the two-port blram arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 32;

    localparam int P_CPU = 0;
    localparam int P_DBG = 1;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a tie goes to the port that was not granted last.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/blram_arbiter.sv
// Shares one single-port blram between the CPU (port 0) and a debug/loader master (port 1).
// Define ARB_LOCK_EN to enable bus locking (LOCK0/LOCK1 FSM with a LOCK_MAX grant limit).
module blram_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p0_lock,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic              p1_lock,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    logic [1:0] req, elig, gnt;
    logic       rr_last_q, rr_last_d, rr_next;
    logic       rd_vld_q, rd_vld_d;
    logic       rd_own_q, rd_own_d;

    assign req = {p1_req, p0_req};

    rr_pick2 u_pick (
        .req  (elig),
        .last (rr_last_q),
        .gnt  (gnt)
    );

    assign rr_next = gnt[P_DBG] ? 1'b1 : (gnt[P_CPU] ? 1'b0 : rr_last_q);

`ifdef ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d, lock_cnt_inc;
    logic             lk_port, lk_req, lk_gnt;

    assign lk_port      = (state_q == LOCK1);
    assign lk_req       = lk_port ? p1_lock : p0_lock;
    assign lk_gnt       = gnt[lk_port];
    assign lock_cnt_inc = lock_cnt_q + 1'b1;

    // While locked only the owner may reach the pick; reset blocks everyone.
    always_comb begin
        elig = req;
        case (state_q)
            LOCK0:   elig = {1'b0, req[P_CPU]};
            LOCK1:   elig = {req[P_DBG], 1'b0};
            default: elig = req;
        endcase
        if (rst) elig = 2'b00;
    end

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        rr_last_d  = rr_next;
        case (state_q)
            ARB: begin
                if (gnt[P_CPU] && p0_lock) begin
                    state_d    = LOCK0;
                    lock_cnt_d = CNT_W'(1);
                end else if (gnt[P_DBG] && p1_lock) begin
                    state_d    = LOCK1;
                    lock_cnt_d = CNT_W'(1);
                end
            end
            default: begin
                if (lk_gnt) lock_cnt_d = lock_cnt_inc;
                if (!lk_req || (lk_gnt && lock_cnt_inc == CNT_MAX)) begin
                    state_d    = ARB;
                    lock_cnt_d = '0;
                    // Forced release hands the next tie to the waiting port.
                    if (lk_req) rr_last_d = lk_port;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end
`else
    logic unused_lock;
    localparam int unused_lock_max = LOCK_MAX;
    assign unused_lock = p0_lock ^ p1_lock;

    always_comb begin
        elig = rst ? 2'b00 : req;
    end

    assign rr_last_d = rr_next;
`endif

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (gnt[P_CPU]) begin
            ram_we    = p0_we;
            ram_addr  = p0_addr;
            ram_wdata = p0_wdata;
        end else if (gnt[P_DBG]) begin
            ram_we    = p1_we;
            ram_addr  = p1_addr;
            ram_wdata = p1_wdata;
        end
    end

    assign rd_vld_d = (|gnt) && !ram_we;
    assign rd_own_d = gnt[P_DBG];

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q <= 1'b1;
            rd_vld_q  <= 1'b0;
            rd_own_q  <= 1'b0;
        end else begin
            rr_last_q <= rr_last_d;
            rd_vld_q  <= rd_vld_d;
            rd_own_q  <= rd_own_d;
        end
    end

    assign p0_gnt    = gnt[P_CPU];
    assign p1_gnt    = gnt[P_DBG];
    // Gated by rst so a read in flight when reset hits returns nothing.
    assign p0_rvalid = rd_vld_q && !rd_own_q && !rst;
    assign p1_rvalid = rd_vld_q && rd_own_q && !rst;
    assign p0_rdata  = ram_rdata;
    assign p1_rdata  = ram_rdata;

endmodule

// File: tb/tb_blram_arbiter.sv
// Directed bench for blram_arbiter with a behavioural 1024-word blram (1-cycle registered read).
module tb_blram_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_req, p0_we, p0_lock, p0_gnt, p0_rvalid;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata, p0_rdata;
    logic          p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    blram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(16)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_lock(p0_lock), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    logic [DW-1:0] mem [0:1023];
    logic          mem_loaded = 1'b0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
            mem[500]   <= 32'd5;
            mem[501]   <= 32'd6;
            mem[502]   <= 32'hb;
            mem_loaded <= 1'b1;
        end else if (ram_we) begin
            mem[ram_addr[9:0]] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr[9:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle();
        p0_req = 1'b0; p0_we = 1'b0; p0_lock = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_lock = 1'b0; p1_addr = '0; p1_wdata = '0;
    endtask

    task automatic both_read();
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 14'd501;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 14'd502;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step(); step();

        // Reset: requests present but nothing granted, RAM idle
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 14'd7;
        p1_req = 1'b1; p1_we = 1'b1;
        smp();
        chk("rst_g0", p0_gnt, 0);
        chk("rst_g1", p1_gnt, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_rv0", p0_rvalid, 0);
        chk("rst_rv1", p1_rvalid, 0);

        // 1: single p0 read of 500
        step(); rst = 1'b0; idle();
        p0_req = 1'b1; p0_addr = 14'd500;
        smp();
        chk("t1_g0", p0_gnt, 1);
        chk("t1_g1", p1_gnt, 0);
        chk("t1_addr", ram_addr, 500);
        step(); idle();
        smp();
        chk("t1_rv0", p0_rvalid, 1);
        chk("t1_rd0", p0_rdata, 5);
        chk("t1_rv1", p1_rvalid, 0);

        // 2: continuous contention; p0 was granted last so p1 leads
        step(); both_read();
        for (int i = 0; i < 6; i++) begin
            smp();
            chk("t2_g1", p1_gnt, (i % 2 == 0) ? 1 : 0);
            chk("t2_g0", p0_gnt, (i % 2 == 0) ? 0 : 1);
            if (i > 0) begin
                if (i % 2 == 1) begin
                    chk("t2_rv1", p1_rvalid, 1);
                    chk("t2_rd1", p1_rdata, 32'hb);
                    chk("t2_rv0x", p0_rvalid, 0);
                end else begin
                    chk("t2_rv0", p0_rvalid, 1);
                    chk("t2_rd0", p0_rdata, 6);
                    chk("t2_rv1x", p1_rvalid, 0);
                end
            end
            step();
        end
        idle();
        smp();
        chk("t2_rv0_last", p0_rvalid, 1);
        chk("t2_rd0_last", p0_rdata, 6);

        // 3: write then read-after-write on the next cycle
        step();
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 14'd200; p1_wdata = 32'h1234;
        smp();
        chk("t3_g1", p1_gnt, 1);
        chk("t3_we", ram_we, 1);
        chk("t3_addr", ram_addr, 200);
        chk("t3_wd", ram_wdata, 32'h1234);
        step(); idle();
        p0_req = 1'b1; p0_addr = 14'd200;
        smp();
        chk("t3_g0", p0_gnt, 1);
        chk("t3_we_rd", ram_we, 0);
        chk("t3_rv1", p1_rvalid, 0);
        step(); idle();
        smp();
        chk("t3_rv0", p0_rvalid, 1);
        chk("t3_rd0", p0_rdata, 32'h1234);

        // 4: reset right after a read grant
        step();
        p0_req = 1'b1; p0_addr = 14'd500;
        smp();
        chk("t4_g0", p0_gnt, 1);
        step(); idle();
        rst = 1'b1;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 14'd3; p1_wdata = 32'hdead;
        smp();
        chk("t4_rv0_rst", p0_rvalid, 0);
        chk("t4_g1_rst", p1_gnt, 0);
        chk("t4_we_rst", ram_we, 0);
        step(); rst = 1'b0; idle();
        p0_req = 1'b1; p0_addr = 14'd500;
        p1_req = 1'b1; p1_addr = 14'd501;
        smp();
        chk("t4_rv0_post", p0_rvalid, 0);
        chk("t4_tie_g0", p0_gnt, 1);
        chk("t4_tie_g1", p1_gnt, 0);
        step(); idle();
        smp();
        chk("t4_rv0", p0_rvalid, 1);
        chk("t4_rd0", p0_rdata, 5);

        // 5: p1 holds lock under contention (p0 granted last, so p1 opens)
        step(); both_read(); p1_lock = 1'b1;
`ifdef ARB_LOCK_EN
        for (int i = 0; i < 17; i++) begin
            smp();
            chk("t5_g1", p1_gnt, (i < 16) ? 1 : 0);
            chk("t5_g0", p0_gnt, (i < 16) ? 0 : 1);
            step();
        end
        idle();

        // 6: p1 releases lock on its third grant
        both_read(); p1_lock = 1'b1;
        smp();
        chk("t6_g1_0", p1_gnt, 1);
        step();
        smp();
        chk("t6_g1_1", p1_gnt, 1);
        chk("t6_cnt1", dut.lock_cnt_q, 1);
        step(); p1_lock = 1'b0;
        smp();
        chk("t6_g1_2", p1_gnt, 1);
        chk("t6_cnt2", dut.lock_cnt_q, 2);
        step();
        smp();
        chk("t6_g0", p0_gnt, 1);
        chk("t6_g1_x", p1_gnt, 0);
        chk("t6_cnt0", dut.lock_cnt_q, 0);
        step(); idle();
`else
        for (int i = 0; i < 6; i++) begin
            smp();
            chk("t5_g1", p1_gnt, (i % 2 == 0) ? 1 : 0);
            chk("t5_g0", p0_gnt, (i % 2 == 0) ? 0 : 1);
            step();
        end
        idle();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
